// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one memory port between fetch and load/store, data first with bounded fetch starvation; define ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES
module rv32i_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [3:0]        d_req_be,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] starve_cnt;
  logic own_d, we_r, err_r;
  logic [3:0] be_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0] wdata_r, rdata_r;
  logic f_force, d_win, f_win, accept, f_mis, d_st, tmo;
  assign f_force = if_req_valid && starve_cnt == 4'(STARVE_LIMIT);
  assign d_win = d_req_valid && !f_force;
  assign f_win = if_req_valid && !d_win;
  assign accept = state == IDLE && (d_win || f_win);
  assign f_mis = f_win && |if_req_addr[1:0];
  assign d_st = d_win && d_req_we;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  // cycles spent in GRANT+WAIT, restarted by every accept
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo_cnt <= '0;
    else tmo_cnt <= accept ? '0 : (state == GRANT || state == WAIT) ? tmo_cnt + TW'(1) : tmo_cnt;
  assign tmo = (state == GRANT || state == WAIT) && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state: misaligned fetches skip the memory, timeout overrides any handshake
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : f_mis ? RESP : GRANT;
      GRANT:   state_nx = tmo ? RESP : mem_gnt ? WAIT : GRANT;
      WAIT:    state_nx = (tmo || mem_rvalid) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // fetch starvation counter: bumped by data wins over a waiting fetch, cleared by fetch wins
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_cnt <= '0;
    else if (accept) starve_cnt <= f_win ? '0 : (if_req_valid && starve_cnt != 4'(STARVE_LIMIT)) ? starve_cnt + 4'd1 : starve_cnt;
  // latched request fields and registered response payload
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      own_d   <= 1'b0;
      we_r    <= 1'b0;
      be_r    <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else if (accept) begin
      own_d   <= d_win;
      we_r    <= d_st;
      be_r    <= d_st ? d_req_be : 4'hF;
      addr_r  <= {d_win ? d_req_addr[ADDR_W-1:2] : if_req_addr[ADDR_W-1:2], 2'b00};
      wdata_r <= d_st ? d_req_wdata : '0;
      rdata_r <= '0;
      err_r   <= f_mis;
    end else if (tmo) begin
      rdata_r <= '0;
      err_r   <= 1'b1;
    end else if (state == WAIT && mem_rvalid) begin
      rdata_r <= we_r ? '0 : mem_rdata;
      err_r   <= mem_err;
    end
  // outputs: readies only while idle, responses decoded from registered state
  always_comb begin
    d_req_ready  = state == IDLE && d_win;
    if_req_ready = state == IDLE && f_win;
    mem_req      = state == GRANT;
    mem_we       = mem_req && we_r;
    mem_be       = be_r;
    mem_addr     = addr_r;
    mem_wdata    = wdata_r;
    if_rsp_valid = state == RESP && !own_d;
    d_rsp_valid  = state == RESP && own_d;
    if_rsp_data  = if_rsp_valid ? rdata_r : '0;
    if_rsp_err   = if_rsp_valid && err_r;
    d_rsp_rdata  = d_rsp_valid ? rdata_r : '0;
    d_rsp_err    = d_rsp_valid && err_r;
  end
endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Shares one single-ported memory between the RV32I core's instruction-fetch path and its load/store path. Accepts one request at a time from either requester via valid/ready, forwards it to the memory port with a req/gnt handshake, waits for the memory response and routes it back to the owner. Data accesses have priority over fetches, with a bounded-starvation rule for fetch. One transaction is outstanding at a time; the arbiter sits between the core's fetch/LSU logic and the shared SRAM/bus port.

## Interface
- ADDR_W, 32, address width of all address ports
- STARVE_LIMIT, 4, consecutive data wins over a waiting fetch before fetch is forced to win (1..15)
- TIMEOUT_CYCLES, 64, cycles in GRANT+WAIT before error abort (only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response, one-cycle pulse
- if_rsp_data  out  32  fetched instruction word
- if_rsp_err  out  1  fetch error (misaligned or timeout)
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_be  in  4  byte enables (stores)
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  32  store data
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  data response, one-cycle pulse (loads and stores)
- d_rsp_rdata  out  32  load data (0 for stores)
- d_rsp_err  out  1  data error (timeout)
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables (4'hF for fetches and loads)
- mem_addr  out  ADDR_W  word address, bits [1:0] forced to 0
- mem_wdata  out  32  memory write data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data
- mem_err  in  1  memory error, qualified by mem_rvalid

## Operation
- States: IDLE, GRANT, WAIT, RESP.
- IDLE: arbitrate. Winner = data if d_req_valid, unless (if_req_valid and starve_cnt == STARVE_LIMIT), then fetch. Winner's ready asserted combinationally; loser's ready 0. Accepted fields and owner are latched; go to GRANT.
- Misaligned fetch (if_req_addr[1:0] != 0): accepted, no memory access, go straight to RESP with if_rsp_err=1, data 0.
- GRANT: mem_req=1 with latched fields, held stable until mem_gnt; on mem_gnt go to WAIT.
- WAIT: mem_req=0; on mem_rvalid latch mem_rdata/mem_err, go to RESP.
- RESP: owner's rsp_valid=1 for exactly one cycle with latched data/err; return to IDLE. No response back-pressure; requesters must sink responses.
- starve_cnt: increments (saturating) when data wins while if_req_valid=1; clears when fetch wins; unchanged otherwise.
- Both readies are 0 in every state except IDLE.

## Timing
- Reset values: all readies, rsp_valids, errs, mem_req, mem_we 0; rsp data 0; mem_be 0; mem_addr/wdata 0; state IDLE; starve_cnt 0.
- Accept in cycle T; mem_req high from T+1; earliest mem_gnt T+1; earliest mem_rvalid T+2 (mem_rvalid in the grant cycle is a protocol violation); earliest rsp_valid T+3; next accept T+4.
- Misaligned fetch: accept T, if_rsp_valid T+1, next accept T+2.
- Responses are registered; no combinational path from mem_* inputs to rsp outputs.
- mem_rvalid outside WAIT is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values; in-flight memory access is abandoned and its response ignored.

## Configuration
- ARB_TIMEOUT_EN defined: a cycle counter runs in GRANT and WAIT, cleared on entry to GRANT; on reaching TIMEOUT_CYCLES the arbiter drops mem_req, goes to RESP with owner's err=1, data 0. Memory must not respond to an aborted access (timeouts are fatal at system level).
- ARB_TIMEOUT_EN undefined: no counter; GRANT/WAIT wait indefinitely.

## Test plan
- Single load: d_req addr 0x10, mem_gnt at T+1, mem_rvalid T+2 data 0xDEADBEEF -> d_rsp_valid at T+3, d_rsp_rdata 0xDEADBEEF, mem_be 4'hF, mem_we 0.
- Store: addr 0x23, be 4'b0011, wdata 0x1234 -> mem_addr 0x20, mem_we 1, mem_be 4'b0011 held until gnt (gnt delayed 3 cycles); d_rsp_valid once, rdata 0.
- Contention: both valid continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Misaligned fetch addr 0x06 -> no mem_req, if_rsp_valid at T+1 with if_rsp_err 1.
- Reset asserted in WAIT -> mem_req 0, state IDLE, no rsp_valid; subsequent late mem_rvalid produces no response.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_gnt never asserted -> mem_req drops after 8 cycles, d_rsp_err 1 next cycle, next request accepted.
